// File: rtl/me_pkg.sv
// Shared sizing helpers and state encoding for the motion-estimation result controller.
package me_pkg;

  function automatic int unsigned range_f(input int unsigned sw_len, input int unsigned tb_len);
    return sw_len - tb_len + 1;
  endfunction

  function automatic int unsigned center_f(input int unsigned sw_len, input int unsigned tb_len);
    return (range_f(sw_len, tb_len) - 1) / 2;
  endfunction

  function automatic int unsigned cnt_width_f(input int unsigned sw_len,
                                              input int unsigned tb_len);
    return $clog2(range_f(sw_len, tb_len) * range_f(sw_len, tb_len));
  endfunction

  function automatic int unsigned sad_width_f(input int unsigned tb_len,
                                              input int unsigned pe_width);
    return $clog2(tb_len * tb_len) + pe_width;
  endfunction

  function automatic int unsigned mv_width_f(input int unsigned sw_len, input int unsigned tb_len);
    return $clog2(range_f(sw_len, tb_len)) + 1;
  endfunction

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StRel,
    StDiv,
    StOut
  } me_state_e;

endpackage

// File: rtl/mvec_divmod.sv
// Iterative subtract-and-count divider splitting a raster index into row (q) and column (r).
module mvec_divmod #(
  parameter int unsigned Range    = 49,
  parameter int unsigned CntWidth = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CntWidth-1:0] idx,
  output logic                done,
  output logic [CntWidth-1:0] q,
  output logic [CntWidth-1:0] r,
  output logic                err
);

  // One extra bit so Range^2 stays representable even when it is a power of two.
  localparam logic [CntWidth:0]   Limit  = (CntWidth + 1)'(Range * Range);
  localparam logic [CntWidth-1:0] RangeW = CntWidth'(Range);

  logic                run_q, run_d;
  logic                err_q, err_d;
  logic [CntWidth-1:0] q_q, q_d;
  logic [CntWidth-1:0] r_q, r_d;

  assign done = run_q && (err_q || (r_q < RangeW));
  assign q    = q_q;
  assign r    = r_q;
  assign err  = err_q;

  always_comb begin
    run_d = run_q;
    err_d = err_q;
    q_d   = q_q;
    r_d   = r_q;
    if (start) begin
      run_d = 1'b1;
      q_d   = '0;
      r_d   = idx;
      err_d = ({1'b0, idx} >= Limit);
    end else if (run_q) begin
      if (done) begin
        run_d = 1'b0;
      end else begin
        r_d = r_q - RangeW;
        q_d = q_q + CntWidth'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      err_q <= 1'b0;
      q_q   <= '0;
      r_q   <= '0;
    end else begin
      run_q <= run_d;
      err_q <= err_d;
      q_q   <= q_d;
      r_q   <= r_d;
    end
  end

endmodule

// File: rtl/me_result_ctrl.sv
// Sequences one me_top search per command and formats the winning position as signed vectors.
module me_result_ctrl
  import me_pkg::*;
#(
  parameter int unsigned TB_LENGTH    = 16,
  parameter int unsigned SW_LENGTH    = 64,
  parameter int unsigned PE_OUT_WIDTH = 8,
  localparam int unsigned RANGE     = range_f(SW_LENGTH, TB_LENGTH),
  localparam int unsigned CENTER    = center_f(SW_LENGTH, TB_LENGTH),
  localparam int unsigned CNT_WIDTH = cnt_width_f(SW_LENGTH, TB_LENGTH),
  localparam int unsigned SAD_WIDTH = sad_width_f(TB_LENGTH, PE_OUT_WIDTH),
  localparam int unsigned MV_WIDTH  = mv_width_f(SW_LENGTH, TB_LENGTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 blk_valid,
  output logic                 blk_ready,
  output logic                 me_req,
  input  logic                 me_ack,
  input  logic [SAD_WIDTH-1:0] me_min_sad,
  input  logic [CNT_WIDTH-1:0] me_min_mvec,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [MV_WIDTH-1:0]  res_mv_x,
  output logic [MV_WIDTH-1:0]  res_mv_y,
  output logic [SAD_WIDTH-1:0] res_sad,
  output logic                 res_err,
  output logic [15:0]          res_blk_cnt,
  output logic                 busy
);

  me_state_e state_q, state_d;

  logic                 me_req_q, me_req_d;
  logic                 res_valid_q, res_valid_d;
  logic                 res_err_q, res_err_d;
  logic [MV_WIDTH-1:0]  res_mv_x_q, res_mv_x_d;
  logic [MV_WIDTH-1:0]  res_mv_y_q, res_mv_y_d;
  logic [SAD_WIDTH-1:0] res_sad_q, res_sad_d;
  logic [15:0]          res_blk_cnt_q, res_blk_cnt_d;
  logic [SAD_WIDTH-1:0] sad_cap_q, sad_cap_d;
  logic [CNT_WIDTH-1:0] idx_cap_q, idx_cap_d;

  logic                 dm_start, dm_done, dm_err;
  logic [CNT_WIDTH-1:0] dm_q, dm_r;

  assign dm_start = (state_q == StRel) && !me_ack;

  mvec_divmod #(
    .Range   (RANGE),
    .CntWidth(CNT_WIDTH)
  ) u_divmod (
    .clk  (clk),
    .rst_n(rst_n),
    .start(dm_start),
    .idx  (idx_cap_q),
    .done (dm_done),
    .q    (dm_q),
    .r    (dm_r),
    .err  (dm_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (blk_valid) state_d = StReq;
      StReq:   if (me_ack)    state_d = StRel;
      StRel:   if (!me_ack)   state_d = StDiv;
      StDiv:   if (dm_done)   state_d = StOut;
      StOut:   if (res_ready) state_d = StIdle;
      default:                state_d = StIdle;
    endcase
  end

  always_comb begin
    me_req_d      = (state_d == StReq);
    res_valid_d   = (state_d == StOut);
    res_err_d     = res_err_q;
    res_mv_x_d    = res_mv_x_q;
    res_mv_y_d    = res_mv_y_q;
    res_sad_d     = res_sad_q;
    res_blk_cnt_d = res_blk_cnt_q;
    sad_cap_d     = sad_cap_q;
    idx_cap_d     = idx_cap_q;
    // Only the REQ->REL edge captures, so a long-held ack cannot overwrite the result.
    if ((state_q == StReq) && me_ack) begin
      sad_cap_d = me_min_sad;
      idx_cap_d = me_min_mvec;
    end
    if ((state_q == StDiv) && dm_done) begin
      res_sad_d = sad_cap_q;
      res_err_d = dm_err;
      if (dm_err) begin
        res_mv_x_d = '0;
        res_mv_y_d = '0;
      end else begin
        res_mv_x_d = MV_WIDTH'(dm_r) - MV_WIDTH'(CENTER);
        res_mv_y_d = MV_WIDTH'(dm_q) - MV_WIDTH'(CENTER);
      end
    end
    if ((state_q == StOut) && res_ready) res_blk_cnt_d = res_blk_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      me_req_q      <= 1'b0;
      res_valid_q   <= 1'b0;
      res_err_q     <= 1'b0;
      res_mv_x_q    <= '0;
      res_mv_y_q    <= '0;
      res_sad_q     <= '0;
      res_blk_cnt_q <= '0;
      sad_cap_q     <= '0;
      idx_cap_q     <= '0;
    end else begin
      me_req_q      <= me_req_d;
      res_valid_q   <= res_valid_d;
      res_err_q     <= res_err_d;
      res_mv_x_q    <= res_mv_x_d;
      res_mv_y_q    <= res_mv_y_d;
      res_sad_q     <= res_sad_d;
      res_blk_cnt_q <= res_blk_cnt_d;
      sad_cap_q     <= sad_cap_d;
      idx_cap_q     <= idx_cap_d;
    end
  end

  assign blk_ready   = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign me_req      = me_req_q;
  assign res_valid   = res_valid_q;
  assign res_err     = res_err_q;
  assign res_mv_x    = res_mv_x_q;
  assign res_mv_y    = res_mv_y_q;
  assign res_sad     = res_sad_q;
  assign res_blk_cnt = res_blk_cnt_q;

endmodule

// File: tb/tb_me_result_ctrl.sv
// Scoreboard bench for me_result_ctrl with a directed me_top handshake model.
module tb_me_result_ctrl;

  localparam int CntW = 12;
  localparam int SadW = 16;
  localparam int MvW  = 7;

  typedef struct packed {
    logic [MvW-1:0]  mv_x;
    logic [MvW-1:0]  mv_y;
    logic [SadW-1:0] sad;
    logic            err;
    logic [15:0]     cnt;
  } res_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            blk_valid = 1'b0;
  logic            blk_ready;
  logic            me_req;
  logic            me_ack = 1'b0;
  logic [SadW-1:0] me_min_sad = '0;
  logic [CntW-1:0] me_min_mvec = '0;
  logic            res_valid;
  logic            res_ready = 1'b1;
  logic [MvW-1:0]  res_mv_x;
  logic [MvW-1:0]  res_mv_y;
  logic [SadW-1:0] res_sad;
  logic            res_err;
  logic [15:0]     res_blk_cnt;
  logic            busy;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   delivered = 0;
  res_t exp_q[$];
  res_t mon_e;

  me_result_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .me_req     (me_req),
    .me_ack     (me_ack),
    .me_min_sad (me_min_sad),
    .me_min_mvec(me_min_mvec),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_mv_x   (res_mv_x),
    .res_mv_y   (res_mv_y),
    .res_sad    (res_sad),
    .res_err    (res_err),
    .res_blk_cnt(res_blk_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic chk_reset(input string name);
    chk(name, {me_req, res_valid, res_err, busy, res_mv_x, res_mv_y, res_sad, res_blk_cnt}, '0);
    chk({name, "_blk_ready"}, blk_ready, 1);
  endtask

  // Monitor: every accepted result is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("res_mv_x", res_mv_x, mon_e.mv_x);
        chk("res_mv_y", res_mv_y, mon_e.mv_y);
        chk("res_sad", res_sad, mon_e.sad);
        chk("res_err", res_err, mon_e.err);
        chk("res_blk_cnt", res_blk_cnt, mon_e.cnt);
      end
    end
  end

  // mode: 0 normal, 1 hold res_ready low 5 cycles, 2 reset while in OUT.
  task automatic run_txn(input int idx, input int sad, input int ex, input int ey,
                         input bit eerr, input int ediv, input int a_dly, input int d_dly,
                         input int mode, input bit issued);
    int   t0;
    bit   seen;
    res_t e;
    e = '{mv_x: MvW'(ex), mv_y: MvW'(ey), sad: SadW'(sad), err: eerr, cnt: 16'(delivered)};
    if (mode != 2) begin
      exp_q.push_back(e);
      delivered++;
    end
    if (!issued) begin
      @(posedge clk); #1;
      blk_valid = 1'b1;
      chk("blk_ready_idle", blk_ready, 1);
    end
    @(posedge clk); #1;
    blk_valid = 1'b0;
    chk("req_after_accept", {busy, me_req, blk_ready}, 3'b110);
    repeat (a_dly) begin
      @(posedge clk); #1;
      chk("req_held", me_req, 1);
    end
    me_ack      = 1'b1;
    me_min_sad  = SadW'(sad);
    me_min_mvec = CntW'(idx);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      seen = !me_req;
    end
    chk("req_release", seen, 1);
    // Corrupt the inputs while ack stays high; only the first ack cycle may be captured.
    me_min_sad  = ~me_min_sad;
    me_min_mvec = CntW'(idx + 777);
    repeat (d_dly) begin
      @(posedge clk); #1;
      chk("no_req_while_ack", {me_req, blk_ready}, 2'b00);
    end
    if (mode != 0) res_ready = 1'b0;
    me_ack = 1'b0;
    t0 = cyc;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      seen = res_valid;
    end
    chk("res_valid_seen", seen, 1);
    chk("div_cycles", 64'(cyc - t0 - 1), 64'(ediv));
    if (mode == 0) begin
      @(posedge clk); #1;
      chk("valid_drop", {res_valid, blk_ready}, 2'b01);
    end else if (mode == 1) begin
      blk_valid = 1'b1;
      repeat (5) begin
        @(posedge clk); #1;
        chk("hold_stable",
            {res_valid, blk_ready, me_req, res_mv_x, res_mv_y, res_sad, res_err, res_blk_cnt},
            {3'b100, e});
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      chk("accept_after_hold", {res_valid, blk_ready}, 2'b01);
    end else begin
      #2 rst_n = 1'b0;
      #1 chk_reset("reset_mid_out");
      @(negedge clk);
      rst_n     = 1'b1;
      res_ready = 1'b1;
      delivered = 0;
      exp_q.delete();
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_reset("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    run_txn(0, 100, -24, -24, 1'b0, 1, 2, 1, 0, 1'b0);
    chk("blk_cnt_first", res_blk_cnt, 1);
    run_txn(1200, 555, 0, 0, 1'b0, 25, 0, 0, 0, 1'b0);
    run_txn(2400, 65535, 24, 24, 1'b0, 49, 1, 2, 0, 1'b0);
    run_txn(2401, 7, 0, 0, 1'b1, 1, 0, 0, 0, 1'b0);
    run_txn(50, 1234, -23, -23, 1'b0, 2, 0, 0, 1, 1'b0);
    // Issued by the held blk_valid of the previous transaction; ack held for 10 cycles.
    run_txn(73, 4321, 0, -23, 1'b0, 2, 0, 9, 0, 1'b1);
    chk("blk_cnt_six", res_blk_cnt, 6);

    @(posedge clk); #1;
    blk_valid = 1'b1;
    @(posedge clk); #1;
    blk_valid = 1'b0;
    chk("req_before_reset", me_req, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset("reset_mid_req");
    @(negedge clk);
    rst_n     = 1'b1;
    delivered = 0;
    exp_q.delete();

    run_txn(98, 42, -24, -22, 1'b0, 3, 1, 1, 0, 1'b0);
    run_txn(48, 9, 24, -24, 1'b0, 1, 0, 0, 2, 1'b0);
    run_txn(2352, 300, -24, 24, 1'b0, 49, 0, 1, 0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk("blk_cnt_final", res_blk_cnt, 1);
    chk("queue_drained", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/me_result_ctrl.md
Name: me_result_ctrl

Overview:
- Sequencer and result formatter directly downstream of me_top.
- Accepts one "search this block" command and drives me_top's req/ack handshake. Captures min_sad/min_mvec.
- Converts the raster search-position index into signed motion-vector components centred on zero. Presents the result on a valid/ready output port for the bitstream/result writer.

Parameters:
- TB_LENGTH, 16, template block edge length in pixels.
- SW_LENGTH, 64, search window edge length in pixels.
- PE_OUT_WIDTH, 8, PE absolute-difference width.
- Derived locals (not overridable):
  - RANGE = SW_LENGTH-TB_LENGTH+1
  - CENTER = (RANGE-1)/2
  - CNT_WIDTH = clog2(RANGE^2)
  - SAD_WIDTH = clog2(TB_LENGTH^2)+PE_OUT_WIDTH
  - MV_WIDTH = clog2(RANGE)+1

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- blk_valid  in  1  command: process next block.
- blk_ready  out  1  command accepted when blk_valid&&blk_ready.
- me_req  out  1  request to me_top.
- me_ack  in  1  me_top done; result valid while high.
- me_min_sad  in  SAD_WIDTH  minimum SAD from me_top.
- me_min_mvec  in  CNT_WIDTH  raster index of best position (row*RANGE+col).
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts result.
- res_mv_x  out  MV_WIDTH  signed horizontal vector, col-CENTER.
- res_mv_y  out  MV_WIDTH  signed vertical vector, row-CENTER.
- res_sad  out  SAD_WIDTH  captured minimum SAD.
- res_err  out  1  index out of range (>=RANGE^2).
- res_blk_cnt  out  16  number of results delivered (wraps).
- busy  out  1  state != IDLE.

Behaviour:
- Reset, asynchronous, any state: state=IDLE. me_req, res_valid, res_err, busy all 0. res_mv_x, res_mv_y, res_sad, res_blk_cnt all 0. me_req deasserts immediately, no clock needed.
- FSM states:
  - IDLE: blk_ready=1. On blk_valid -> REQ.
  - REQ: me_req=1. Wait for me_ack=1. On the first cycle with me_ack=1, latch me_min_sad and me_min_mvec -> REL. Only one capture per command.
  - REL: me_req=0. Wait for me_ack=0 (4-phase handshake) -> DIV. A long-held ack causes no further capture.
  - DIV: quotient/remainder registers start at q=0, r=captured index. Each cycle, if r>=RANGE then r-=RANGE and q++; else -> OUT.
    - This takes floor(idx/RANGE)+1 cycles.
    - Illegal index (>=RANGE^2) is detected at capture. It skips the loop (one DIV cycle) and sets the error flag.
  - OUT: res_valid=1. On exit from DIV:
    - res_mv_x = r-CENTER and res_mv_y = q-CENTER, both two's complement, computed in MV_WIDTH+1 and then truncated.
    - If illegal: mv_x = mv_y = 0 and res_err=1.
    - On res_valid&&res_ready, res_blk_cnt++ (wraps 0xFFFF->0) and go to IDLE.
- Outputs are held stable while res_valid && !res_ready.
- blk_ready=0 in every state except IDLE. No command buffering.
- res_* are held after the transfer until the next OUT entry. res_valid is 0 outside OUT.
- All outputs are registered except blk_ready and busy, which decode state.
- Latency, blk accept to res_valid, with ack arriving A cycles after req and ack low D cycles after rise: 1 + A + D + (floor(idx/RANGE)+1) + 1 cycles.

Decomposition:
- Shared package me_pkg:
  - RANGE, CENTER, CNT_WIDTH, SAD_WIDTH, MV_WIDTH derivation functions.
  - State encoding enum {IDLE, REQ, REL, DIV, OUT}.
- One natural sub-module: mvec_divmod. It is the iterative subtract-and-count unit, with start/done, idx in, q/r/err out. The FSM instantiates it for the DIV state.

Test Plan (defaults RANGE=49, CENTER=24; a me_top model returns programmed values):
- me_min_mvec=0, sad=100 -> res_mv_x=-24, res_mv_y=-24, res_sad=100, err=0; 1 DIV cycle; res_blk_cnt 0->1.
- me_min_mvec=1200 (row24,col24) -> res_mv_x=0, res_mv_y=0. Exactly 25 DIV cycles between ack-low and res_valid, counted.
- me_min_mvec=2400 -> mv=(+24,+24); 49 DIV cycles. me_min_mvec=2401 -> err=1, mv=(0,0).
- Hold res_ready=0 for 5 cycles with blk_valid=1 -> res_* stable, blk_ready=0, no me_req. Result transfers on the ready cycle, then the next command is accepted.
- me_ack held high 10 cycles with me_min_mvec changing after the first -> value from the first ack cycle is captured; me_req stays 0 until ack falls and the next command arrives.
- Assert rst_n=0 mid-REQ and mid-OUT -> me_req and res_valid go 0 asynchronously, all outputs return to reset values, and the next blk_valid after release starts a clean transaction.
